// File: rtl/fancy_counter_seq_if.sv
// fancy_counter_seq_if
// Command and response channels between a host and fancy_counter_seq.
//   cmd_valid/cmd_ready/cmd_op/cmd_len : command channel, host -> sequencer
//   rsp_valid/rsp_ready/rsp_data/rsp_fancy/rsp_err : response channel, sequencer -> host
// master modport is the host side, slave modport is the sequencer side.
interface fancy_counter_seq_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_len;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [W-1:0] rsp_fancy;
    logic         rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_fancy, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_fancy, rsp_err
    );
endinterface

// File: rtl/fancy_counter_seq.sv
// fancy_counter_seq
// Runs RUN/CLEAR/READ commands against a single fancy counter: drives its
// enable for an exact number of cycles or pulses its reset, then captures
// the counter outputs and returns them on the response channel.
// Ports:
//   clk, nreset      : clock, synchronous active-low reset
//   bus (slave)      : command / response handshake channels
//   cnt_en           : counter enable (registered)
//   cnt_nreset       : counter synchronous reset, active-low
//   cnt_data/fancy   : counter outputs, captured in CAP
//   busy             : high whenever the sequencer is not idle
module fancy_counter_seq #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    fancy_counter_seq_if.slave   bus,
    output logic                 cnt_en,
    output logic                 cnt_nreset,
    input  logic [W-1:0]         cnt_data,
    input  logic [W-1:0]         cnt_fancy,
    output logic                 busy
);
    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        CLR  = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t       state, next_state;
    logic [W-1:0] remaining;
    logic [1:0]   op_q;
    logic [W-1:0] rsp_data_q;
    logic [W-1:0] rsp_fancy_q;
    logic         rsp_err_q;
    logic         accept;

    assign accept = bus.cmd_valid && (state == IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_RUN)
                        next_state = (bus.cmd_len == '0) ? CAP : RUN;
                    else if (bus.cmd_op == OP_CLEAR)
                        next_state = CLR;
                    else
                        next_state = CAP;   // READ and reserved op
                end
            end
            // remaining is at least 1 whenever RUN is entered
            RUN:     if (remaining == W'(1)) next_state = CAP;
            CLR:     next_state = CAP;
            CAP:     next_state = RSP;
            RSP:     if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            cnt_en      <= 1'b0;
            remaining   <= '0;
            op_q        <= 2'd0;
            rsp_data_q  <= '0;
            rsp_fancy_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state  <= next_state;
            // registered so the enable lines up exactly with RUN cycles
            cnt_en <= (next_state == RUN);
            if (accept) begin
                remaining <= bus.cmd_len;
                op_q      <= bus.cmd_op;
            end else if (state == RUN) begin
                remaining <= remaining - W'(1);
            end
            if (state == CAP) begin
                rsp_data_q  <= cnt_data;
                rsp_fancy_q <= cnt_fancy;
                rsp_err_q   <= (op_q == OP_RSVD);
            end
        end
    end

    // Block reset passes straight through so the counter clears on the same edge.
    assign cnt_nreset    = nreset && (state != CLR);
    assign busy          = (state != IDLE);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fancy = rsp_fancy_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_fancy_counter_seq.sv
module tb_fancy_counter_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic nreset;
    logic cnt_en, cnt_nreset, busy;
    logic [W-1:0] cdata;
    logic [W-1:0] cnt_data, cnt_fancy;

    fancy_counter_seq_if #(.W(W)) bus ();

    fancy_counter_seq #(.W(W)) dut (
        .clk(clk), .nreset(nreset), .bus(bus),
        .cnt_en(cnt_en), .cnt_nreset(cnt_nreset),
        .cnt_data(cnt_data), .cnt_fancy(cnt_fancy), .busy(busy)
    );

    always #5 clk = ~clk;

    // fancy_data as a function of data: the reference counter's values at
    // the points the test plan names, an arbitrary mixing function elsewhere.
    function automatic logic [W-1:0] fancy_of(input logic [W-1:0] d);
        case (d)
            16'd0:     return 16'd17;
            16'd1:     return 16'd1287;
            16'd17:    return 16'd2137;
            16'd20:    return 16'd27;
            16'd65535: return 16'd65535;
            default:   return (d * 16'd37 + 16'd17) ^ 16'h5a5a;
        endcase
    endfunction

    // stand-in counter driven by the DUT
    always @(posedge clk) begin
        if (!cnt_nreset) cdata <= '0;
        else if (cnt_en) cdata <= cdata + 16'd1;
    end
    assign cnt_data  = cdata;
    assign cnt_fancy = fancy_of(cdata);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // scoreboard
    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] f;
        logic         e;
        int           acc;
        int           lat;
        int           en;
        int           clr;
    } exp_t;
    exp_t sb[$];

    int cnt_m = 0;         // reference counter value
    int last_hs = -1;
    int ready_mode = 0;    // 0 random, 1 hold low, 2 hold high

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       bus.rsp_ready = 1'b0;
            2:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // monitor
    int en_cnt = 0;
    int clr_cnt = 0;
    logic vld_q = 1'b0;
    always @(negedge clk) begin
        if (nreset !== 1'b1) begin
            en_cnt  = 0;
            clr_cnt = 0;
            vld_q   = 1'b0;
        end else begin
            if (cnt_en) en_cnt++;
            if (!cnt_nreset) clr_cnt++;
            if (bus.rsp_valid && !vld_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    chk("en_cycles",   32'(en_cnt),          32'(sb[0].en));
                    chk("clr_cycles",  32'(clr_cnt),         32'(sb[0].clr));
                end
                en_cnt  = 0;
                clr_cnt = 0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() != 0) begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("rsp_data",  32'(bus.rsp_data),  32'(x.d));
                    chk("rsp_fancy", 32'(bus.rsp_fancy), 32'(x.f));
                    chk("rsp_err",   32'(bus.rsp_err),   32'(x.e));
                end
                last_hs = cyc;
            end
            vld_q = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    // reference model: advance counter value and push the expected response
    task automatic model_push(input logic [1:0] op, input logic [W-1:0] len, input int acc);
        exp_t x;
        if (op == 2'd0) cnt_m = (cnt_m + int'(len)) % 65536;
        else if (op == 2'd1) cnt_m = 0;
        x.d   = W'(cnt_m);
        x.f   = fancy_of(W'(cnt_m));
        x.e   = (op == 2'd3);
        x.acc = acc;
        x.lat = (op == 2'd0 && len != 0) ? int'(len) + 2 : (op == 2'd1 ? 3 : 2);
        x.en  = (op == 2'd0) ? int'(len) : 0;
        x.clr = (op == 2'd1) ? 1 : 0;
        sb.push_back(x);
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] len, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        @(negedge clk);
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            expired("cmd_accept");
            bus.cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        model_push(op, len, acc);
        @(posedge clk); #1;
        // scramble after accept; the sequencer must ignore these
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_len   = W'($urandom);
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        @(negedge clk);
        while (sb.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            expired("drain");
            sb.delete();
        end
    endtask

    initial begin
        int a, a2, t;
        nreset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cnt_en",    32'(cnt_en),        32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("rst_rsp_fancy", 32'(bus.rsp_fancy), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_cnt_nreset", 32'(cnt_nreset),   32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(negedge clk);
        chk("rel_cnt_nreset", 32'(cnt_nreset),   32'd1);

        // directed sequence from the test plan
        send(2'd2, 16'd0, a);     drain(50);   // READ 0/17
        send(2'd0, 16'd1, a);     drain(50);   // 1/1287
        send(2'd0, 16'd16, a);    drain(80);   // 17/2137
        send(2'd0, 16'd3, a);     drain(50);   // 20/27
        send(2'd1, 16'd9, a);     drain(50);   // CLEAR 0/17
        send(2'd0, 16'd0, a);     drain(50);   // RUN 0
        send(2'd0, 16'd65535, a); drain(66000);
        send(2'd0, 16'd1, a);     drain(50);   // wrap to 0
        send(2'd3, 16'd5, a);     drain(50);   // reserved op
        send(2'd0, 16'd7, a);     drain(50);
        send(2'd3, 16'd0, a);     drain(50);

        // response stall: fields stable, no enables, pending command held off
        send(2'd2, 16'd0, a);
        @(negedge clk);
        ready_mode = 1;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin @(negedge clk); t++; end
        if (!bus.rsp_valid) expired("stall_rsp");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_len   = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",     32'(bus.rsp_valid), 32'd1);
            chk("stall_data",      32'(bus.rsp_data),  32'(sb[0].d));
            chk("stall_fancy",     32'(bus.rsp_fancy), 32'(sb[0].f));
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("stall_cnt_en",    32'(cnt_en),        32'd0);
        end
        ready_mode = 2;
        t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 20) begin @(negedge clk); t++; end
        if (!bus.cmd_ready) expired("stall_accept");
        a2 = cyc;
        chk("accept_after_hs", 32'(a2), 32'(last_hs + 1));
        model_push(2'd2, 16'd0, a2);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        drain(50);
        ready_mode = 0;

        // reset in the middle of RUN 100 at the 50th enable cycle
        send(2'd0, 16'd100, a);
        repeat (49) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(negedge clk);
        chk("mid_en_before", 32'(cnt_en), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_en_after",     32'(cnt_en),        32'd0);
        chk("mid_busy",         32'(busy),          32'd0);
        chk("mid_rsp_valid",    32'(bus.rsp_valid), 32'd0);
        chk("mid_rsp_data",     32'(bus.rsp_data),  32'd0);
        chk("mid_cnt_nreset",   32'(cnt_nreset),    32'd0);
        chk("mid_sb_pending",   32'(sb.size()),     32'd1);
        if (sb.size() != 0) void'(sb.pop_back());
        cnt_m = 0;
        @(posedge clk); #1;
        nreset = 1'b1;
        @(negedge clk);
        chk("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        send(2'd2, 16'd0, a); drain(50);

        // randomized commands, back to back with random gaps
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            logic [W-1:0] len;
            op  = 2'($urandom_range(0, 3));
            len = (op == 2'd0) ? W'($urandom_range(0, 40)) : W'($urandom);
            send(op, len, a);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fancy_counter_seq.md
# fancy_counter_seq

Command-driven sequencer for the fancy counter. It accepts run/clear/read commands over a valid/ready handshake and drives the counter's `en` and `nreset` for an exact number of cycles. It then captures the counter's `data`/`fancy_data` and returns them on a valid/ready response channel. It sits between a host-side control path and a single fancy counter instance, and is the only driver of that counter.

## Interface
- `W`, 16, width of counter data, fancy data and run length.
- `clk`  in  1  clock; all state changes on rising edge.
- `nreset`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  2  0=RUN, 1=CLEAR, 2=READ, 3=reserved.
- `cmd_len`  in  W  RUN length in enable cycles; ignored for other ops.
- `cnt_en`  out  1  counter enable.
- `cnt_nreset`  out  1  counter synchronous reset, active-low.
- `cnt_data`  in  W  counter `data`.
- `cnt_fancy`  in  W  counter `fancy_data`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  W  captured `cnt_data`.
- `rsp_fancy`  out  W  captured `cnt_fancy`.
- `rsp_err`  out  1  response belongs to a reserved op.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, RUN, CLR, CAP, RSP.
- IDLE:
  - `cmd_ready`=1; accept on `cmd_valid && cmd_ready`.
  - Load `remaining`=`cmd_len` and latch `op`.
  - RUN with len>0 -> RUN; RUN with len=0 -> CAP; CLEAR -> CLR; READ -> CAP; op 3 -> CAP, with `rsp_err` set in the response.
- RUN: `cnt_en`=1 and `remaining` decrements each cycle. In the cycle where `remaining`==1, the next state is CAP.
- CLR: `cnt_nreset`=0 for exactly one cycle, `cnt_en`=0; next state is CAP.
- CAP: `cnt_en`=0; at the end of the cycle, register `cnt_data`, `cnt_fancy` and `rsp_err` into the response registers; next state is RSP.
- RSP:
  - `rsp_valid`=1; the response registers stay stable until `rsp_valid && rsp_ready`, then return to IDLE.
  - `cnt_en`=0 throughout.
- `cnt_en` and the FSM are registered. `cnt_nreset` = `nreset && (state != CLR)`, so counter reset follows block reset in the same cycle.
- `remaining` is an unsigned W-bit value. Max run is 2^W-1 cycles, and the counter wraps naturally.
- `cmd_ready` is low in every state except IDLE. There is no command queueing, and a command presented while busy is held off by the handshake.
- `cmd_op`/`cmd_len` are sampled only on the accept cycle. Later changes have no effect.
- Reset (`nreset`=0 at a rising edge), from any state including mid-RUN:
  - next cycle: state IDLE, `cnt_en`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_fancy`=0, `rsp_err`=0, `remaining`=0, `busy`=0, `cmd_ready`=1.
  - The counter is cleared in the same edge via `cnt_nreset`.
  - An interrupted command produces no response.

## Timing
- Let A be the cycle in which a command is accepted.
- RUN L≥1: `cnt_en` is high in cycles A+1..A+L exactly (L enable cycles), CAP is at A+L+1, and `rsp_valid` rises at A+L+2.
- RUN L=0, READ, op 3: CAP at A+1, `rsp_valid` at A+2.
- CLEAR: `cnt_nreset` is low in A+1, CAP at A+2, `rsp_valid` at A+3.
- Response accepted in cycle R: `busy`=0 and `cmd_ready`=1 from R+1. The minimum issue interval for READ is therefore 3 cycles.
- Captured values reflect the counter after all enable edges of the command.

## Test plan
- Reset, then READ -> `rsp_data`=0, `rsp_fancy`=17, `rsp_err`=0; `rsp_valid` appears exactly 2 cycles after accept.
- RUN 1 -> 1/1287. Then RUN 16 -> 17/2137. Then RUN 3 -> 20/27. Count `cnt_en` high cycles = L each time, with no enable outside RUN.
- CLEAR after counting -> `cnt_nreset` low for exactly one cycle, response 0/17. Then RUN 0 -> 0/17 with no `cnt_en` pulse.
- From 0, RUN 65535 -> 65535/65535, then RUN 1 -> wraps to 0/17. Op 3 -> `rsp_err`=1 with current counter values.
- Hold `rsp_ready` low for 5 cycles during RSP -> response fields are stable, `cmd_ready`=0, `cnt_en`=0, and a pending `cmd_valid` is not accepted until after the response handshake.
- RUN 100, assert `nreset` low at the 50th enable cycle for 2 cycles -> no response, `cnt_en` drops the cycle after reset is sampled, `cmd_ready`=1 after release, and READ returns 0/17.
